// File: rtl/contador_ascendente.sv
// rtl/contador_ascendente.sv - prescaled up-counter to a sampled target with two-digit seven-segment display
module contador_ascendente #(
  parameter int N   = 6,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         run,
  input  logic [N-1:0] a,
  output logic [N-1:0] z,
  output logic         busy,
  output logic         done,
  output logic [6:0]   digit0,
  output logic [6:0]   digit1
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(DIV - 1);

  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

  state_t        state;
  logic [N-1:0]  target;
  logic [PW-1:0] prescaler;
  logic [N-1:0]  z_inc;
  logic [6:0]    z_wide;

  assign z_inc = z + N'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      z         <= '0;
      target    <= '0;
      prescaler <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      // start restarts from any state and takes priority over an increment
      target    <= a;
      z         <= '0;
      prescaler <= '0;
      if (a == '0) begin
        state <= DONE;
        busy  <= 1'b0;
        done  <= 1'b1;
      end else begin
        state <= COUNT;
        busy  <= 1'b1;
        done  <= 1'b0;
      end
    end else if (state == COUNT && run) begin
      if (prescaler == PS_LAST) begin
        prescaler <= '0;
        z         <= z_inc;
        if (z_inc == target) begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
      end else begin
        prescaler <= prescaler + PW'(1);
      end
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  assign z_wide = 7'(z);
  assign digit1 = seg7(4'(z_wide / 7'd10));
  assign digit0 = seg7(4'(z_wide % 7'd10));

endmodule
